switcher_row_sequencer: RTL
===========================

Name: switcher_row_sequencer

Overview:
- Control block in the DCD-emulator core, clocked by CLK_80.
- Consumes the deserialized switcher word SW_DES[15:0] (GATE, CLEAR, FRAME and CLK, 4 samples each at 320 Mb/s) and reconstructs the switcher sequence.
- Generates frame/row strobes and the current row address that pace the DCD data generator feeding DO0_i..DO7_i.
- Drives the DISABLE_DO mask so that DO pins are blanked during CLEAR phases.

Parameters:
- ROWS, 192, number of switcher rows per frame; ROW_ADDR wraps after ROWS-1.
- ROW_W, 8, width of ROW_ADDR; must satisfy 2^ROW_W >= ROWS.

Ports:
- CLK_80 in 1: system clock, 80 MHz; all logic is on the rising edge.
- RST_N in 1: synchronous, active-low reset.
- ENABLE in 1: when 0, the sequencer is held in IDLE with outputs at reset values.
- SW_DES in 16: samples; [15:12]=GATE, [11:8]=CLEAR, [7:4]=FRAME, [3:0]=CLK. Within each nibble, bit 0 is the earliest sample and bit 3 the latest.
- BLANK_ON_CLEAR in 1: when 1, CLEAR activity forces all DISABLE_DO bits high.
- DISABLE_CFG in 64: static per-pin disable, ORed into DISABLE_DO.
- ERR_CLR in 1: single-cycle pulse that clears SEQ_ERR.
- FRAME_START out 1: 1-cycle pulse on a FRAME rising edge.
- ROW_STROBE out 1: 1-cycle pulse on each accepted SW_CLK rising edge.
- ROW_ADDR out ROW_W: row index valid with ROW_STROBE; held between strobes.
- ROW_PHASE out 2: sample index (0..3) of the SW_CLK edge that produced the current strobe.
- GATE_ON out 1: 1 if any GATE sample in the word is high.
- CLEAR_ON out 1: 1 if any CLEAR sample in the word is high.
- DISABLE_DO out 64: equals DISABLE_CFG | {64{CLEAR_ON & BLANK_ON_CLEAR}}.
- SEQ_ERR out 2: sticky. bit0 = more than one SW_CLK edge in one word; bit1 = row overflow without FRAME.
- STATE out 2: 0 IDLE, 1 ARMED, 2 RUN.

Behaviour:
- Reset (RST_N=0 at a clock edge), and also ENABLE=0:
  - State goes to IDLE.
  - All outputs go to 0, except DISABLE_DO = DISABLE_CFG.
  - Previous-sample registers go to 0.
  - SEQ_ERR is cleared by reset only, not by ENABLE=0.
- Edge detection: for each signal, form a 5-bit vector {nibble, last sample of previous word}. A rising edge at position k (0..3) exists when sample k=1 and sample k-1=0. Position k=0 compares against the stored previous bit 3.
- Latency: a word presented at cycle N produces all strobes and levels at cycle N+1 (one register stage). DISABLE_DO follows CLEAR_ON with the same latency.
- IDLE:
  - FRAME edge: FRAME_START=1, ROW_ADDR is cleared to 0, go to ARMED.
  - SW_CLK edges are ignored.
- ARMED:
  - First SW_CLK edge: ROW_STROBE=1, ROW_ADDR=0, ROW_PHASE=k, go to RUN.
  - A further FRAME edge re-arms: FRAME_START pulses again, no error.
- RUN:
  - Each SW_CLK edge sets ROW_STROBE=1 and ROW_ADDR=ROW_ADDR+1.
  - At ROW_ADDR=ROWS-1, the next edge wraps ROW_ADDR to 0, still strobes, and sets SEQ_ERR[1].
  - A FRAME edge gives FRAME_START=1, ROW_ADDR=0, and a return to ARMED.
- FRAME edge and SW_CLK edge in the same word:
  - FRAME takes precedence.
  - The CLK edge is treated as the first row (strobe, addr 0, state RUN) only if its position is strictly greater than the FRAME edge position. Otherwise it is discarded and the state stays ARMED.
- Two or more SW_CLK edges in one word:
  - Only the earliest edge is accepted (one strobe, one increment).
  - SEQ_ERR[0] is set.
- ERR_CLR=1 clears SEQ_ERR. An error event in the same cycle wins, so the bit stays set.
- ENABLE falling mid-frame behaves exactly like reset, except that SEQ_ERR is held. ENABLE rising resumes in IDLE and waits for FRAME.
- GATE_ON and CLEAR_ON are pure level ORs of their nibbles, registered. They are independent of the state machine.

Test Plan:
- Reset: RST_N=0 with SW_DES=16'hFFFF, DISABLE_CFG=64'h5 -> STATE=0, strobes 0, SEQ_ERR=0, DISABLE_DO=64'h5.
- Nominal frame: FRAME nibble 4'b1100, then 4 words with CLK nibble 4'b0011 separated by 4'b0000 words -> FRAME_START one cycle later; ROW_STROBE×4 with ROW_ADDR 0,1,2,3 and ROW_PHASE=0.
- Same-word ordering: FRAME=4'b1110 with CLK=4'b1000 -> FRAME_START and ROW_STROBE with addr 0, phase 3, STATE=2. Repeat with CLK=4'b0001 -> no strobe, STATE=1.
- Double edge: in RUN, CLK nibble 4'b0101 -> one strobe, addr +1, phase 0, SEQ_ERR=2'b01. ERR_CLR pulse -> SEQ_ERR=0.
- Wrap: ROWS=4, 5 CLK edges after FRAME -> ROW_ADDR 0,1,2,3,0; SEQ_ERR[1]=1 on the fifth strobe.
- Blanking: BLANK_ON_CLEAR=1, CLEAR nibble 4'b0010 for 1 word -> CLEAR_ON and DISABLE_DO=all ones for exactly 1 cycle, one cycle later. Then ENABLE=0 mid-RUN -> STATE=0, ROW_ADDR=0, SEQ_ERR held.

Source files
------------

// File: rtl/switcher_row_sequencer.sv
// switcher_row_sequencer
//   Rebuilds the switcher sequence from the deserialized switcher word. It
//   paces the DCD data generator with frame and row strobes and a row address.
//   It also blanks the DO pins while CLEAR is active.
//
// Ports
//   CLK_80         80 MHz clock; every register updates on its rising edge
//   RST_N          synchronous, active-low reset
//   ENABLE         0 holds the sequencer in IDLE with outputs cleared
//   SW_DES[15:0]   {GATE, CLEAR, FRAME, CLK}; 4 samples per nibble, bit 0 is earliest
//   BLANK_ON_CLEAR 1 lets CLEAR activity force every DISABLE_DO bit high
//   DISABLE_CFG    static per-pin disable mask
//   ERR_CLR        clears SEQ_ERR; an error in the same cycle still sets its bit
//   FRAME_START    1-cycle pulse on a FRAME rising edge
//   ROW_STROBE     1-cycle pulse on each accepted SW_CLK rising edge
//   ROW_ADDR       row index, valid with ROW_STROBE and held between strobes
//   ROW_PHASE      sample index of the SW_CLK edge behind the current strobe
//   GATE_ON        any GATE sample high in the previous word
//   CLEAR_ON       any CLEAR sample high in the previous word
//   DISABLE_DO     DISABLE_CFG | {64{CLEAR_ON & BLANK_ON_CLEAR}}
//   SEQ_ERR        sticky: [0] multiple SW_CLK edges in one word, [1] row overflow
//   STATE          0 IDLE, 1 ARMED, 2 RUN
module switcher_row_sequencer #(
    parameter int ROWS  = 192,
    parameter int ROW_W = 8
) (
    input  logic             CLK_80,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic [15:0]      SW_DES,
    input  logic             BLANK_ON_CLEAR,
    input  logic [63:0]      DISABLE_CFG,
    input  logic             ERR_CLR,
    output logic             FRAME_START,
    output logic             ROW_STROBE,
    output logic [ROW_W-1:0] ROW_ADDR,
    output logic [1:0]       ROW_PHASE,
    output logic             GATE_ON,
    output logic             CLEAR_ON,
    output logic [63:0]      DISABLE_DO,
    output logic [1:0]       SEQ_ERR,
    output logic [1:0]       STATE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    // Rising-edge mask of one nibble. Sample 0 is compared with the last
    // sample of the previous word.
    function automatic logic [3:0] rise_mask(input logic [3:0] nib, input logic prev);
        rise_mask = nib & ~{nib[2:0], prev};
    endfunction

    function automatic logic [1:0] first_pos(input logic [3:0] m);
        if (m[0])      first_pos = 2'd0;
        else if (m[1]) first_pos = 2'd1;
        else if (m[2]) first_pos = 2'd2;
        else           first_pos = 2'd3;
    endfunction

    function automatic logic more_than_one(input logic [3:0] m);
        more_than_one = (m & (m - 4'd1)) != 4'd0;
    endfunction

    logic             prev_frame_p1;
    logic             prev_clk_p1;

    logic [3:0]       f_mask_p0;
    logic [3:0]       c_mask_p0;
    logic [1:0]       f_pos_p0;
    logic [1:0]       c_pos_p0;
    logic             frame_start_p0;
    logic             row_strobe_p0;
    logic [ROW_W-1:0] row_addr_p0;
    logic [1:0]       row_phase_p0;
    logic [1:0]       state_p0;
    logic [1:0]       err_ev_p0;
    logic [1:0]       seq_err_p0;

    // Stage p0: edge detection and next-state decision from the incoming word
    always_comb begin
        f_mask_p0      = rise_mask(SW_DES[7:4], prev_frame_p1);
        c_mask_p0      = rise_mask(SW_DES[3:0], prev_clk_p1);
        f_pos_p0       = first_pos(f_mask_p0);
        c_pos_p0       = first_pos(c_mask_p0);
        frame_start_p0 = 1'b0;
        row_strobe_p0  = 1'b0;
        row_addr_p0    = ROW_ADDR;
        row_phase_p0   = ROW_PHASE;
        state_p0       = STATE;
        err_ev_p0      = {1'b0, more_than_one(c_mask_p0)};

        if (|f_mask_p0) begin
            // FRAME wins. A CLK edge strictly after it in the same word
            // becomes row 0 of the new frame.
            frame_start_p0 = 1'b1;
            row_addr_p0    = '0;
            state_p0       = ST_ARMED;
            if ((|c_mask_p0) && (c_pos_p0 > f_pos_p0)) begin
                row_strobe_p0 = 1'b1;
                row_phase_p0  = c_pos_p0;
                state_p0      = ST_RUN;
            end
        end else if (|c_mask_p0) begin
            case (STATE)
                ST_ARMED: begin
                    row_strobe_p0 = 1'b1;
                    row_addr_p0   = '0;
                    row_phase_p0  = c_pos_p0;
                    state_p0      = ST_RUN;
                end
                ST_RUN: begin
                    row_strobe_p0 = 1'b1;
                    row_phase_p0  = c_pos_p0;
                    if (ROW_ADDR == LAST_ROW) begin
                        row_addr_p0  = '0;
                        err_ev_p0[1] = 1'b1;
                    end else begin
                        row_addr_p0 = ROW_ADDR + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end

        seq_err_p0 = (ERR_CLR ? 2'b00 : SEQ_ERR) | err_ev_p0;
    end

    // Stage p1: registered strobes, levels and sequencer state
    always_ff @(posedge CLK_80) begin
        if (!RST_N) begin
            STATE         <= ST_IDLE;
            FRAME_START   <= 1'b0;
            ROW_STROBE    <= 1'b0;
            ROW_ADDR      <= '0;
            ROW_PHASE     <= 2'd0;
            GATE_ON       <= 1'b0;
            CLEAR_ON      <= 1'b0;
            prev_frame_p1 <= 1'b0;
            prev_clk_p1   <= 1'b0;
            SEQ_ERR       <= 2'b00;
        end else if (!ENABLE) begin
            // Same as reset, except the sticky errors survive.
            STATE         <= ST_IDLE;
            FRAME_START   <= 1'b0;
            ROW_STROBE    <= 1'b0;
            ROW_ADDR      <= '0;
            ROW_PHASE     <= 2'd0;
            GATE_ON       <= 1'b0;
            CLEAR_ON      <= 1'b0;
            prev_frame_p1 <= 1'b0;
            prev_clk_p1   <= 1'b0;
            SEQ_ERR       <= ERR_CLR ? 2'b00 : SEQ_ERR;
        end else begin
            STATE         <= state_p0;
            FRAME_START   <= frame_start_p0;
            ROW_STROBE    <= row_strobe_p0;
            ROW_ADDR      <= row_addr_p0;
            ROW_PHASE     <= row_phase_p0;
            GATE_ON       <= |SW_DES[15:12];
            CLEAR_ON      <= |SW_DES[11:8];
            prev_frame_p1 <= SW_DES[7];
            prev_clk_p1   <= SW_DES[3];
            SEQ_ERR       <= seq_err_p0;
        end
    end

    assign DISABLE_DO = DISABLE_CFG | {64{CLEAR_ON & BLANK_ON_CLEAR}};

endmodule
